// File: rtl/axis_serdes_pkg.sv
// Framing definitions shared by the SERDES transmit and receive halves:
// FSM states, default frame layout and the even-parity helper.
package axis_serdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } serdes_state_e;

  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_SYNC_W       = 8;
  localparam logic [7:0]  DEF_SYNC_PATTERN = 8'hD5;
  localparam int unsigned DEF_GAP_BITS     = 2;
  localparam int unsigned DEF_FRAME_BITS   = DEF_SYNC_W + DEF_DATA_W + 32'd1 + DEF_GAP_BITS;

  // Payloads are zero-extended to this width before the parity reduction.
  localparam int unsigned PARITY_IN_W = 64;

  function automatic logic even_parity(input logic [PARITY_IN_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/axis_serdes_bit_timer.sv
// Bit-period counter: bit_tick marks the last clock of each serial bit-time.
module axis_serdes_bit_timer
  import axis_serdes_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned     CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count clocks within a bit-time; frozen while the line is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (run) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bit_tick = (cnt_r == CNT_MAX);

endmodule

// File: rtl/axis_serdes_tx.sv
// AXI-stream to serial transmitter: SYNC, DATA (MSB first), even parity, idle gap.
// A one-word holding register lets the next word be accepted while a frame shifts.
module axis_serdes_tx
  import axis_serdes_pkg::*;
#(
  parameter int unsigned       DATA_W       = DEF_DATA_W,
  parameter int unsigned       SYNC_W       = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DEF_SYNC_PATTERN),
  parameter int unsigned       GAP_BITS     = DEF_GAP_BITS,
  parameter int unsigned       CLKS_PER_BIT = 1,
  parameter logic              IDLE_LEVEL   = 1'b0
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_reset_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              tx_enable,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic [15:0]       frame_count
);

  localparam int unsigned FRAME_SR_W = SYNC_W + DATA_W + 1;
  localparam int unsigned MAX_SD     = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned MAX_FIELD  = (MAX_SD > GAP_BITS) ? MAX_SD : GAP_BITS;
  localparam int unsigned BIT_CNT_W  = $clog2(MAX_FIELD + 1);
  localparam logic [BIT_CNT_W-1:0] SYNC_LAST = BIT_CNT_W'(SYNC_W - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] GAP_LAST  = BIT_CNT_W'(GAP_BITS - 1);

  serdes_state_e          state_r, state_next_s;
  logic                   ready_en_r, hold_full_r;
  logic [DATA_W-1:0]      hold_r;
  logic [FRAME_SR_W-1:0]  frame_sr_r;
  logic [BIT_CNT_W-1:0]   bit_cnt_r;
  logic                   tx_serial_r;
  logic [15:0]            frame_count_r;
  logic                   bit_tick_s, handshake_s, load_s, shift_s;
  logic                   bit_clr_s, bit_inc_s, frame_inc_s, line_s;
  logic [PARITY_IN_W-1:0] parity_in_s;

  assign s_axis_tready = ready_en_r & ~hold_full_r;
  assign handshake_s   = s_axis_tvalid & s_axis_tready;
  assign parity_in_s   = PARITY_IN_W'(hold_r);
  assign tx_busy       = (state_r != ST_IDLE);
  assign tx_serial     = tx_serial_r;
  assign frame_count   = frame_count_r;

  axis_serdes_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (s_axis_aclk),
    .rst_n    (s_axis_reset_n),
    .run      (tx_busy),
    .clear    (load_s),
    .bit_tick (bit_tick_s)
  );

  // FSM state register.
  always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
    if (!s_axis_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, line level and datapath controls.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    bit_clr_s    = 1'b0;
    bit_inc_s    = 1'b0;
    frame_inc_s  = 1'b0;
    line_s       = IDLE_LEVEL;
    case (state_r)
      ST_IDLE: begin
        if (hold_full_r && tx_enable) begin
          load_s       = 1'b1;
          bit_clr_s    = 1'b1;
          state_next_s = ST_SYNC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        line_s = frame_sr_r[FRAME_SR_W-1];
        if (bit_tick_s) begin
          shift_s = 1'b1;
          if (bit_cnt_r == SYNC_LAST) begin
            bit_clr_s    = 1'b1;
            state_next_s = ST_DATA;
          end else begin
            bit_inc_s = 1'b1;
          end
        end else begin
          shift_s = 1'b0;
        end
      end
      ST_DATA: begin
        line_s = frame_sr_r[FRAME_SR_W-1];
        if (bit_tick_s) begin
          shift_s = 1'b1;
          if (bit_cnt_r == DATA_LAST) begin
            bit_clr_s    = 1'b1;
            state_next_s = ST_PARITY;
          end else begin
            bit_inc_s = 1'b1;
          end
        end else begin
          shift_s = 1'b0;
        end
      end
      ST_PARITY: begin
        line_s = frame_sr_r[FRAME_SR_W-1];
        if (bit_tick_s) begin
          frame_inc_s  = 1'b1;
          bit_clr_s    = 1'b1;
          state_next_s = ST_GAP;
        end else begin
          frame_inc_s = 1'b0;
        end
      end
      ST_GAP: begin
        line_s = IDLE_LEVEL;
        if (bit_tick_s) begin
          if (bit_cnt_r == GAP_LAST) begin
            bit_clr_s    = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            bit_inc_s = 1'b1;
          end
        end else begin
          bit_inc_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Ready enable and the one-word holding register.
  always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
    if (!s_axis_reset_n) begin
      ready_en_r  <= 1'b0;
      hold_full_r <= 1'b0;
      hold_r      <= '0;
    end else begin
      ready_en_r <= 1'b1;
      if (handshake_s) begin
        hold_r      <= s_axis_tdata;
        hold_full_r <= 1'b1;
      end else if (load_s) begin
        hold_full_r <= 1'b0;
      end else begin
        hold_full_r <= hold_full_r;
      end
    end
  end

  // Frame shifter holds {sync, payload, parity}; the line always shows its MSB.
  always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
    if (!s_axis_reset_n) begin
      frame_sr_r <= '0;
      bit_cnt_r  <= '0;
    end else begin
      if (load_s) begin
        frame_sr_r <= {SYNC_PATTERN, hold_r, even_parity(parity_in_s)};
      end else if (shift_s) begin
        frame_sr_r <= {frame_sr_r[FRAME_SR_W-2:0], 1'b0};
      end else begin
        frame_sr_r <= frame_sr_r;
      end
      if (bit_clr_s) begin
        bit_cnt_r <= '0;
      end else if (bit_inc_s) begin
        bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  // Registered line output and completed-frame counter.
  always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
    if (!s_axis_reset_n) begin
      tx_serial_r   <= IDLE_LEVEL;
      frame_count_r <= 16'd0;
    end else begin
      tx_serial_r <= line_s;
      if (frame_inc_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

endmodule

// File: tb/tb_axis_serdes_tx.sv
// Self-checking bench: table of words with hand-computed parity, a line monitor
// feeding a frame scoreboard, and hand sequences for streaming, enable and reset.
module tb_axis_serdes_tx;
  import axis_serdes_pkg::*;

  localparam int FB = DEF_FRAME_BITS;

  typedef struct {
    logic [31:0] word;
    logic        parity;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tdata, tdata4;
  logic        tvalid, tvalid4, tready, tready4;
  logic        tx_enable, en4;
  logic        tx_serial, tx_serial4, tx_busy, tx_busy4;
  logic [15:0] frame_count, frame_count4;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int frames_seen = 0;
  int last_start_cyc = 0;
  int start_q[$];
  logic [FB-1:0] exp_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_serdes_tx dut (
    .s_axis_aclk(clk), .s_axis_reset_n(rst_n), .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .tx_enable(tx_enable),
    .tx_serial(tx_serial), .tx_busy(tx_busy), .frame_count(frame_count)
  );

  axis_serdes_tx #(.CLKS_PER_BIT(4)) dut4 (
    .s_axis_aclk(clk), .s_axis_reset_n(rst_n), .s_axis_tdata(tdata4),
    .s_axis_tvalid(tvalid4), .s_axis_tready(tready4), .tx_enable(en4),
    .tx_serial(tx_serial4), .tx_busy(tx_busy4), .frame_count(frame_count4)
  );

  function automatic logic [FB-1:0] ref_frame(input logic [31:0] w, input logic p);
    return {8'hD5, w, p, 2'b00};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Offer one word; the expected frame is queued when the handshake edge is reached.
  task automatic send(input logic [31:0] w, input logic [FB-1:0] exp_frame, input logic keep);
    int n;
    n = 0;
    @(negedge clk);
    tdata  = w;
    tvalid = 1'b1;
    while (tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: tready stayed %b, required 1", tready);
    end
    exp_q.push_back(exp_frame);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    if (!keep) begin
      @(negedge clk);
      tvalid = 1'b0;
    end
  endtask

  task automatic wait_frames(input int target, input string name);
    int n;
    n = 0;
    while (frames_seen < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(frames_seen >= target), 64'd1);
  endtask

  // Line monitor: captures a whole frame (including gap) from its first sync bit.
  initial begin : monitor
    logic [FB-1:0] got, exp;
    logic aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_serial === 1'b1) begin
        got = '0;
        got[FB-1] = 1'b1;
        aborted = 1'b0;
        last_start_cyc = cyc;
        start_q.push_back(cyc);
        for (int i = FB - 2; i >= 0; i--) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          got[i] = tx_serial;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_unexpected: got %0h, required no frame", got);
          end else begin
            exp = exp_q.pop_front();
            check("frame_bits", 64'(got), 64'(exp));
          end
          frames_seen++;
        end
      end
    end
  end

  initial begin : main
    int fs, busy_cnt, ones_cnt, bad4;
    logic [FB-1:0] f4;
    logic [31:0] w;
    vecs[0] = '{32'hDEADBEEF, 1'b0};
    vecs[1] = '{32'h00000001, 1'b1};
    vecs[2] = '{32'h00000000, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 1'b0};
    vecs[4] = '{32'h80000000, 1'b1};
    vecs[5] = '{32'h12345678, 1'b1};
    tdata = 32'd0; tvalid = 1'b0; tx_enable = 1'b1;
    tdata4 = 32'd0; tvalid4 = 1'b0; en4 = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_tx_serial", 64'(tx_serial), 64'd0);
    check("rst_tx_busy", 64'(tx_busy), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_tready", 64'(tready), 64'd0);
    rst_n = 1'b1;
    #1 check("tready_before_first_edge", 64'(tready), 64'd0);
    @(negedge clk);
    check("tready_after_first_edge", 64'(tready), 64'd1);

    // CLKS_PER_BIT=4: every bit held 4 clocks, 172 busy clocks.
    f4 = ref_frame(32'hA5A5A5A5, 1'b0);
    tdata4 = 32'hA5A5A5A5;
    tvalid4 = 1'b1;
    @(posedge clk);
    busy_cnt = 0;
    bad4 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) tvalid4 = 1'b0;
      busy_cnt += int'(tx_busy4);
      if (i >= 2 && i < 174) begin
        if (tx_serial4 !== f4[FB - 1 - (i - 2) / 4]) bad4++;
      end else begin
        if (tx_serial4 !== 1'b0) bad4++;
      end
    end
    check("cpb4_bit_mismatches", 64'(bad4), 64'd0);
    check("cpb4_busy_cycles", 64'(busy_cnt), 64'd172);
    check("cpb4_frame_count", 64'(frame_count4), 64'd1);

    // Table-driven single frames with hand-computed parity.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].word, ref_frame(vecs[i].word, vecs[i].parity), 1'b0);
      wait_frames(i + 1, "table_frame_done");
      check("table_latency", 64'(last_start_cyc - hs_cyc), 64'd2);
      check("table_frame_count", 64'(frame_count), 64'(i + 1));
    end

    // Streaming: tvalid held high for four words.
    fs = frames_seen;
    start_q.delete();
    for (int k = 0; k < 4; k++) begin
      w = $urandom;
      send(w, ref_frame(w, ^w), 1'b1);
      if (k == 1) check("stream_tready_low_when_full", 64'(tready), 64'd0);
    end
    @(negedge clk);
    tvalid = 1'b0;
    wait_frames(fs + 4, "stream_frames_done");
    for (int k = 0; k < 3; k++) begin
      if (start_q.size() > k + 1) check("stream_frame_spacing", 64'(start_q[k+1] - start_q[k]), 64'd44);
      else check("stream_frame_starts", 64'(start_q.size()), 64'd4);
    end
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
    check("stream_frame_count", 64'(frame_count), 64'd10);

    // tx_enable dropped mid-DATA with a second word buffered.
    fs = frames_seen;
    send(32'hCAFEF00D, ref_frame(32'hCAFEF00D, 1'b0), 1'b0);
    repeat (20) @(negedge clk);
    send(32'h0F0F0F01, ref_frame(32'h0F0F0F01, 1'b1), 1'b0);
    @(negedge clk);
    tx_enable = 1'b0;
    wait_frames(fs + 1, "enable_first_done");
    busy_cnt = 0;
    ones_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      busy_cnt += int'(tx_busy);
      ones_cnt += int'(tx_serial);
    end
    check("enable_off_busy", 64'(busy_cnt), 64'd0);
    check("enable_off_line", 64'(ones_cnt), 64'd0);
    check("enable_off_tready", 64'(tready), 64'd0);
    tx_enable = 1'b1;
    wait_frames(fs + 2, "enable_second_done");
    check("enable_frame_count", 64'(frame_count), 64'd12);

    // Asynchronous reset mid-DATA.
    send(32'h13579BDF, ref_frame(32'h13579BDF, 1'b0), 1'b0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_serial", 64'(tx_serial), 64'd0);
    check("midrst_tx_busy", 64'(tx_busy), 64'd0);
    check("midrst_frame_count", 64'(frame_count), 64'd0);
    check("midrst_tready", 64'(tready), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_tready_at_release", 64'(tready), 64'd0);
    @(negedge clk);
    check("midrst_tready_one_cycle_later", 64'(tready), 64'd1);
    fs = frames_seen;
    send(32'h2468ACE0, ref_frame(32'h2468ACE0, 1'b0), 1'b0);
    wait_frames(fs + 1, "midrst_next_frame_done");
    check("midrst_latency", 64'(last_start_cyc - hs_cyc), 64'd2);
    check("midrst_frame_count", 64'(frame_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
